// File: rtl/ahb_slavemux_n.sv
// -----------------------------------------------------------------------------
// ahb_slavemux_n
//
// Purpose:
//   AHB-Lite slave-side response multiplexer for NUM_SLV slaves. It captures
//   the address-phase slave select when i_hready=1. During the following data
//   phase it routes the selected slave's HREADYOUT, HRESP and HRDATA back to
//   the master. Active transfers that select no slave are answered by a
//   built-in default slave with the standard two-cycle ERROR response.
//
// Optional feature (macro AHB_SLAVEMUX_TIMEOUT_EN):
//   Defining the macro adds a data-phase stall watchdog. If the selected slave
//   holds HREADYOUT low for TO_CYCLES consecutive data-phase cycles, the
//   transfer is aborted with an ERROR response. The watchdog then raises the
//   sticky o_to_flag, which stays set until i_hreset. When the macro is not
//   defined, the watchdog is not built, o_to_flag is tied low and a stalled
//   data phase waits indefinitely.
//
// Parameters:
//   NUM_SLV    number of slave ports (1..16)
//   DW         read-data width per slave
//   TO_CYCLES  stall limit in data-phase cycles (2..255), used only with the
//              watchdog
//
// Ports:
//   i_hclk         clock, all state changes on the rising edge
//   i_hreset       synchronous active-high reset
//   i_hready       HREADY fed back from the bus
//   i_htrans       address-phase transfer type (bit 1 set = NONSEQ/SEQ)
//   i_hsel         address-phase slave selects, one bit per slave
//   i_hreadyout_s  per-slave HREADYOUT
//   i_hresp_s      per-slave HRESP
//   i_hrdata_s     per-slave HRDATA, slave i at [i*DW +: DW]
//   o_hreadyout    HREADY to the master and to the slaves
//   o_hresp        HRESP to the master
//   o_hrdata       HRDATA to the master
//   o_to_flag      sticky stall-timeout indicator
// -----------------------------------------------------------------------------
module ahb_slavemux_n #(
    parameter int unsigned NUM_SLV   = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hready,
    input  logic [1:0]            i_htrans,
    input  logic [NUM_SLV-1:0]    i_hsel,
    input  logic [NUM_SLV-1:0]    i_hreadyout_s,
    input  logic [NUM_SLV-1:0]    i_hresp_s,
    input  logic [NUM_SLV*DW-1:0] i_hrdata_s,
    output logic                  o_hreadyout,
    output logic                  o_hresp,
    output logic [DW-1:0]         o_hrdata,
    output logic                  o_to_flag
);

    localparam int unsigned IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StErr1 = 2'd2,
        StErr2 = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e          r_state;
    logic            r_sel_vld;   // a slave owns the current data phase
    logic [IW-1:0]   r_sel_idx;   // index of that slave

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_e          w_state_nxt;
    logic            w_sel_vld_nxt;
    logic [IW-1:0]   w_sel_idx_nxt;

    logic            w_any_sel;
    logic [IW-1:0]   w_lo_idx;
    logic            w_slv_rdy;
    logic            w_slv_resp;
    logic [DW-1:0]   w_slv_rdata;
    logic            w_stalled;
    logic            w_timeout;

    // -------------------------------------------------------------------------
    // Address-phase select decode: lowest asserted index wins.
    // Scanning from the top down lets the lowest set bit overwrite the rest.
    // -------------------------------------------------------------------------
    assign w_any_sel = |i_hsel;

    always_comb begin
        w_lo_idx = '0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if (i_hsel[i]) begin
                w_lo_idx = IW'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Data-phase response mux. A compare loop is used instead of a variable
    // index, so an index encoding above NUM_SLV-1 selects nothing.
    // -------------------------------------------------------------------------
    always_comb begin
        w_slv_rdy   = 1'b1;
        w_slv_resp  = 1'b0;
        w_slv_rdata = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (r_sel_idx == IW'(i)) begin
                w_slv_rdy   = i_hreadyout_s[i];
                w_slv_resp  = i_hresp_s[i];
                w_slv_rdata = i_hrdata_s[i*DW +: DW];
            end
        end
    end

    assign w_stalled = (r_state == StData) && r_sel_vld && !w_slv_rdy;

    // -------------------------------------------------------------------------
    // Optional stall watchdog
    // -------------------------------------------------------------------------
`ifdef AHB_SLAVEMUX_TIMEOUT_EN
    logic [7:0] r_stall_cnt;
    logic       r_to_flag;

    // The count equals the number of stalled cycles already seen. The limit
    // therefore fires on the TO_CYCLES-th consecutive stalled cycle.
    assign w_timeout = w_stalled && (r_stall_cnt == 8'(TO_CYCLES - 1));

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_stall_cnt <= 8'd0;
            r_to_flag   <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_stall_cnt <= 8'd0;
                r_to_flag   <= 1'b1;
            end else if (w_stalled) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end else begin
                r_stall_cnt <= 8'd0;
            end
        end
    end

    assign o_to_flag = r_to_flag;
`else
    assign w_timeout = 1'b0;
    assign o_to_flag = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM state and sampled-select registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state   <= StIdle;
            r_sel_vld <= 1'b0;
            r_sel_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_vld <= w_sel_vld_nxt;
            r_sel_idx <= w_sel_idx_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_vld_nxt = r_sel_vld;
        w_sel_idx_nxt = r_sel_idx;

        unique case (r_state)
            StIdle, StData: begin
                if (w_timeout) begin
                    // Abort the stalled transfer; the slave is masked from now on.
                    w_state_nxt   = StErr1;
                    w_sel_vld_nxt = 1'b0;
                    w_sel_idx_nxt = '0;
                end else if (i_hready) begin
                    // A new address phase is accepted only when the bus is ready.
                    w_sel_vld_nxt = i_htrans[1] && w_any_sel;
                    w_sel_idx_nxt = (i_htrans[1] && w_any_sel) ? w_lo_idx : '0;
                    if (i_htrans[1]) begin
                        w_state_nxt = w_any_sel ? StData : StErr1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
                // If i_hready is low, the data phase is still in progress: hold.
            end

            StErr1: begin
                w_state_nxt   = StErr2;
                w_sel_vld_nxt = 1'b0;
                w_sel_idx_nxt = '0;
            end

            StErr2: begin
                // The master sees the second ERROR cycle; its next address is dropped.
                w_state_nxt   = StIdle;
                w_sel_vld_nxt = 1'b0;
                w_sel_idx_nxt = '0;
            end

            default: begin
                w_state_nxt   = StIdle;
                w_sel_vld_nxt = 1'b0;
                w_sel_idx_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. Reset forces the idle response right away, so the bus
    // sees a clean OKAY/ready response during reset, even before the first
    // clock edge.
    // -------------------------------------------------------------------------
    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        o_hrdata    = '0;

        if (!i_hreset) begin
            unique case (r_state)
                StData: begin
                    if (r_sel_vld) begin
                        o_hreadyout = w_slv_rdy;
                        o_hresp     = w_slv_resp;
                        o_hrdata    = w_slv_rdata;
                    end
                end
                StErr1: begin
                    o_hreadyout = 1'b0;
                    o_hresp     = 1'b1;
                end
                StErr2: begin
                    o_hreadyout = 1'b1;
                    o_hresp     = 1'b1;
                end
                default: begin
                    o_hreadyout = 1'b1;
                    o_hresp     = 1'b0;
                end
            endcase
        end
    end

endmodule
